// File: rtl/tmds_pll_supervisor.sv
// tmds_pll_supervisor
//   Bring-up and lock supervisor for the TMDS PLL that produces the DVI
//   serializer (5x) and pixel (1x) clocks. Runs entirely in the PLL
//   reference-clock domain (clkin).
//
//   Sequence: pulse PLL reset -> wait for lock -> qualify lock stability
//   -> release serializer reset -> hold -> release pixel reset (RUN).
//   A lock timeout retries the sequence; once the retry budget is spent
//   the block parks in FAULT until restart_i or reset.
//   Loss of lock in REL_SER/RUN re-runs the whole sequence and is counted.
//
//   Optional build macro: TMDS_PLL_SUP_LOCK_FILTER_EN
//     When defined, lock_s must stay low for LOSS_FILTER_CYC consecutive
//     cycles in REL_SER/RUN before it counts as a loss; shorter dips are
//     ignored. When undefined, a single low lock_s cycle is a loss.

module tmds_pll_supervisor #(
    parameter int unsigned PLL_RST_CYC      = 16,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
    parameter int unsigned MAX_RETRY        = 7,
    parameter int unsigned SER_RST_HOLD     = 8,
    parameter int unsigned LOSS_FILTER_CYC  = 4
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock_i,
    input  logic       restart_i,
    output logic       pll_reset_o,
    output logic       ser_rst_o,
    output logic       pix_rst_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    // ------------------------------------------------------------------
    // Counter sizing: each counter only has to hold (parameter - 1).
    // ------------------------------------------------------------------
    localparam int unsigned RST_W  = (PLL_RST_CYC      > 1) ? $clog2(PLL_RST_CYC)      : 1;
    localparam int unsigned STB_W  = (LOCK_STABLE_CYC  > 1) ? $clog2(LOCK_STABLE_CYC)  : 1;
    localparam int unsigned TO_W   = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;
    localparam int unsigned HOLD_W = (SER_RST_HOLD     > 1) ? $clog2(SER_RST_HOLD)     : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYC - 1);
    // The WAIT_LOCK cycle that first sees lock_s=1 is the first qualified
    // cycle, and the STABLE cycle where the counter reads N is qualified
    // cycle N+2. Release therefore happens when the counter reads CYC-2.
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYC - 2);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SER_RST_HOLD - 1);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [3:0] RETRY_SAT   = 4'hF;
    localparam logic [7:0] LOSS_SAT    = 8'hFF;

    // Reject parameter sets the sequencer cannot honour.
    if (PLL_RST_CYC == 0 || LOCK_STABLE_CYC < 2 || LOCK_TIMEOUT_CYC == 0 ||
        MAX_RETRY == 0 || MAX_RETRY > 15 || SER_RST_HOLD == 0 ||
        LOSS_FILTER_CYC == 0) begin : g_bad_params
        $error("tmds_pll_supervisor: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_SER   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t            r_state;
    logic [RST_W-1:0]  r_rst_cnt;
    logic [STB_W-1:0]  r_stable_cnt;
    logic [TO_W-1:0]   r_timer;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic       r_lock_meta;
    logic       r_lock_s;

    logic       r_pll_reset;
    logic       r_ser_rst;
    logic       r_pix_rst;
    logic       r_ready;
    logic       r_fault;
    logic [3:0] r_retry_cnt;
    logic [7:0] r_loss_cnt;

    logic       w_timeout;
    logic [3:0] w_retry_next;
    logic       w_lock_loss;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clkin
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking so the second flop takes the first flop's
            // pre-edge value; blocking here would collapse the two stages.
            r_lock_meta <= pll_lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

`ifdef TMDS_PLL_SUP_LOCK_FILTER_EN
    localparam int unsigned FLT_W = (LOSS_FILTER_CYC > 1) ? $clog2(LOSS_FILTER_CYC) : 1;
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOSS_FILTER_CYC - 1);

    logic [FLT_W-1:0] r_low_cnt;
    logic             r_loss_det;

    // Count consecutive low lock_s samples; flag a loss once the dip persists
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_low_cnt  <= '0;
            r_loss_det <= 1'b0;
        end else if (r_lock_s) begin
            r_low_cnt  <= '0;
            r_loss_det <= 1'b0;
        end else begin
            if (r_low_cnt != FLT_LAST) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
            r_loss_det <= (r_low_cnt == FLT_LAST);
        end
    end

    assign w_lock_loss = r_loss_det;
`else
    assign w_lock_loss = ~r_lock_s;
`endif

    assign w_timeout    = (r_timer == TO_LAST);
    assign w_retry_next = (r_retry_cnt == RETRY_SAT) ? RETRY_SAT : r_retry_cnt + 4'd1;

    // Bring-up sequencer: state, phase counters, timeout timer and registered outputs
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state      <= ST_RST_PLL;
            r_rst_cnt    <= '0;
            r_stable_cnt <= '0;
            r_timer      <= '0;
            r_hold_cnt   <= '0;
            r_pll_reset  <= 1'b1;
            r_ser_rst    <= 1'b1;
            r_pix_rst    <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
            r_retry_cnt  <= '0;
            r_loss_cnt   <= '0;
        end else if (restart_i) begin
            // Full re-run from any state; the loss history is kept.
            r_state     <= ST_RST_PLL;
            r_rst_cnt   <= '0;
            r_timer     <= '0;
            r_pll_reset <= 1'b1;
            r_ser_rst   <= 1'b1;
            r_pix_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            case (r_state)
                ST_RST_PLL: begin
                    r_timer <= '0;
                    if (r_rst_cnt == RST_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_rst_cnt   <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end

                // The timer spans both states so a chattering lock still times out.
                ST_WAIT_LOCK, ST_STABLE: begin
                    if (w_timeout) begin
                        r_timer     <= '0;
                        r_retry_cnt <= w_retry_next;
                        r_pll_reset <= 1'b1;
                        if (w_retry_next == RETRY_LIMIT) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state   <= ST_RST_PLL;
                            r_rst_cnt <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (r_state == ST_WAIT_LOCK) begin
                            if (r_lock_s) begin
                                r_state      <= ST_STABLE;
                                r_stable_cnt <= '0;
                            end
                        end else if (!r_lock_s) begin
                            r_state <= ST_WAIT_LOCK;
                        end else if (r_stable_cnt == STB_LAST) begin
                            r_state    <= ST_REL_SER;
                            r_ser_rst  <= 1'b0;
                            r_hold_cnt <= '0;
                        end else begin
                            r_stable_cnt <= r_stable_cnt + 1'b1;
                        end
                    end
                end

                // A loss while releasing is handled exactly like a loss in RUN.
                ST_REL_SER, ST_RUN: begin
                    if (w_lock_loss) begin
                        r_state     <= ST_RST_PLL;
                        r_rst_cnt   <= '0;
                        r_timer     <= '0;
                        r_pll_reset <= 1'b1;
                        r_ser_rst   <= 1'b1;
                        r_pix_rst   <= 1'b1;
                        r_ready     <= 1'b0;
                        if (r_loss_cnt != LOSS_SAT) begin
                            r_loss_cnt <= r_loss_cnt + 1'b1;
                        end
                    end else if (r_state == ST_REL_SER) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state     <= ST_RUN;
                            r_pix_rst   <= 1'b0;
                            r_ready     <= 1'b1;
                            r_retry_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    r_pll_reset <= 1'b1;
                    r_ser_rst   <= 1'b1;
                    r_pix_rst   <= 1'b1;
                    r_ready     <= 1'b0;
                    r_fault     <= 1'b1;
                end

                // NOTE: unused encodings recover to a safe bring-up rather than
                // holding an undefined state forever.
                default: begin
                    r_state     <= ST_RST_PLL;
                    r_rst_cnt   <= '0;
                    r_timer     <= '0;
                    r_pll_reset <= 1'b1;
                    r_ser_rst   <= 1'b1;
                    r_pix_rst   <= 1'b1;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset_o = r_pll_reset;
    assign ser_rst_o   = r_ser_rst;
    assign pix_rst_o   = r_pix_rst;
    assign ready_o     = r_ready;
    assign fault_o     = r_fault;
    assign retry_cnt_o = r_retry_cnt;
    assign loss_cnt_o  = r_loss_cnt;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// tb_tmds_pll_supervisor
//   Directed bench for tmds_pll_supervisor with small parameters:
//   PLL_RST_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=64, MAX_RETRY=3,
//   SER_RST_HOLD=2. Expected cycle counts are hand-derived constants.
`timescale 1ns/1ps

module tb_tmds_pll_supervisor;

    localparam int PLL_RST_CYC      = 4;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int LOCK_TIMEOUT_CYC = 64;
    localparam int MAX_RETRY        = 3;
    localparam int SER_RST_HOLD     = 2;
    localparam int LOSS_FILTER_CYC  = 4;

    // Restart/loss to ready: 4 PLL reset + 1 lock seen + 7 stable + 2 hold
    localparam int RESEQ_CYC = 14;

    localparam int SIG_PLL = 0;
    localparam int SIG_SER = 1;
    localparam int SIG_PIX = 2;
    localparam int SIG_RDY = 3;

    logic       clkin      = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       restart_i  = 1'b0;
    logic       pll_reset_o;
    logic       ser_rst_o;
    logic       pix_rst_o;
    logic       ready_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    int exp_loss;
    int t_at [3];
    int t_hits;
    logic [3:0] prev_retry;
    logic flag;

    tmds_pll_supervisor #(
        .PLL_RST_CYC      (PLL_RST_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .MAX_RETRY        (MAX_RETRY),
        .SER_RST_HOLD     (SER_RST_HOLD),
        .LOSS_FILTER_CYC  (LOSS_FILTER_CYC)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .pll_lock_i  (pll_lock_i),
        .restart_i   (restart_i),
        .pll_reset_o (pll_reset_o),
        .ser_rst_o   (ser_rst_o),
        .pix_rst_o   (pix_rst_o),
        .ready_o     (ready_o),
        .fault_o     (fault_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o)
    );

    always #5 clkin = ~clkin;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clkin);
        #1;
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            SIG_PLL: return pll_reset_o;
            SIG_SER: return ser_rst_o;
            SIG_PIX: return pix_rst_o;
            default: return ready_o;
        endcase
    endfunction

    // Count edges until the selected output equals level; -1 on expiry.
    task automatic wait_sig(input string tag, input int sel, input logic level,
                            input int budget, output int cycles);
        cycles = 0;
        while (get_sig(sel) !== level && cycles < budget) begin
            tick(1);
            cycles++;
        end
        if (get_sig(sel) !== level) begin
            check({tag, "_timeout"}, 32'(get_sig(sel)), 32'(level));
            cycles = -1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset_o), 1);
        check({tag, "_ser_rst"},   32'(ser_rst_o),   1);
        check({tag, "_pix_rst"},   32'(pix_rst_o),   1);
        check({tag, "_ready"},     32'(ready_o),     0);
        check({tag, "_fault"},     32'(fault_o),     0);
        check({tag, "_retry"},     32'(retry_cnt_o), 0);
        check({tag, "_loss"},      32'(loss_cnt_o),  0);
    endtask

    initial begin
        // ---------------- 1. Bring-up ----------------
        do_reset();
        check_reset_vals("rst");
        wait_sig("bringup_pll_hi", SIG_PLL, 1'b0, 20, n);
        check("bringup_pll_hi_cycles", n, PLL_RST_CYC);
        tick(10);
        check("bringup_wait_ready", 32'(ready_o), 0);
        pll_lock_i = 1'b1;
        wait_sig("bringup_ser", SIG_SER, 1'b0, 50, n);
        check("bringup_ser_cycles", n, 2 + LOCK_STABLE_CYC);
        check("bringup_pix_still_high", 32'(pix_rst_o), 1);
        wait_sig("bringup_pix", SIG_PIX, 1'b0, 20, n);
        check("bringup_pix_cycles", n, SER_RST_HOLD);
        check("bringup_ready", 32'(ready_o), 1);
        check("bringup_retry", 32'(retry_cnt_o), 0);
        check("bringup_pll_low", 32'(pll_reset_o), 0);

        // ---------------- 4. One-cycle lock dip in RUN ----------------
        pll_lock_i = 1'b0;
        tick(1);
        pll_lock_i = 1'b1;
`ifdef TMDS_PLL_SUP_LOCK_FILTER_EN
        exp_loss = 0;
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (!ready_o) flag = 1'b1;
        end
        check("dip_filtered_ready_drop", 32'(flag), 0);
        check("dip_filtered_loss", 32'(loss_cnt_o), 0);
`else
        exp_loss = 1;
        wait_sig("dip_ready_fall", SIG_RDY, 1'b0, 10, n);
        check("dip_ready_fall_cycles", n + 1, 3);
        check("dip_pll_reset", 32'(pll_reset_o), 1);
        check("dip_ser_rst", 32'(ser_rst_o), 1);
        check("dip_pix_rst", 32'(pix_rst_o), 1);
        check("dip_loss", 32'(loss_cnt_o), 1);
        wait_sig("dip_reseq", SIG_RDY, 1'b1, 100, n);
        check("dip_reseq_cycles", n, RESEQ_CYC);
`endif
        // restart in RUN keeps the loss count
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        check("restart_run_ready", 32'(ready_o), 0);
        check("restart_run_loss", 32'(loss_cnt_o), 32'(exp_loss));
        wait_sig("restart_run_reseq", SIG_RDY, 1'b1, 100, n);
        check("restart_run_reseq_cycles", n, RESEQ_CYC);

        // ---------------- 2. No lock ever ----------------
        pll_lock_i = 1'b0;
        do_reset();
        for (int p = 1; p <= MAX_RETRY; p++) begin
            wait_sig("nolock_pulse", SIG_PLL, 1'b0, 20, n);
            check("nolock_pulse_cycles", n, PLL_RST_CYC);
            wait_sig("nolock_wait", SIG_PLL, 1'b1, 200, n);
            check("nolock_wait_cycles", n, LOCK_TIMEOUT_CYC);
            check("nolock_retry", 32'(retry_cnt_o), 32'(p));
        end
        check("nolock_fault", 32'(fault_o), 1);
        flag = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (!pll_reset_o || !ser_rst_o || !pix_rst_o || ready_o || !fault_o) flag = 1'b1;
        end
        check("nolock_fault_held", 32'(flag), 0);
        check("nolock_retry_held", 32'(retry_cnt_o), 3);

        // ---------------- 3. Lock chatter 5 high / 1 low ----------------
        do_reset();
        t_at[0] = 0; t_at[1] = 0; t_at[2] = 0;
        t_hits = 0;
        prev_retry = retry_cnt_o;
        flag = 1'b0;
        for (int cyc = 0; cyc < 400 && !fault_o; cyc++) begin
            pll_lock_i = ((cyc % 6) != 5);
            tick(1);
            if (retry_cnt_o != prev_retry) begin
                if (t_hits < 3) t_at[t_hits] = cyc + 1;
                t_hits++;
                prev_retry = retry_cnt_o;
            end
            if (!ser_rst_o) flag = 1'b1;
        end
        check("chatter_fault", 32'(fault_o), 1);
        check("chatter_retry", 32'(retry_cnt_o), 3);
        check("chatter_first_timeout", t_at[0], PLL_RST_CYC + LOCK_TIMEOUT_CYC);
        check("chatter_spacing_1", t_at[1] - t_at[0], PLL_RST_CYC + LOCK_TIMEOUT_CYC);
        check("chatter_spacing_2", t_at[2] - t_at[1], PLL_RST_CYC + LOCK_TIMEOUT_CYC);
        check("chatter_never_released", 32'(flag), 0);

        // ---------------- 5. Restart out of FAULT ----------------
        pll_lock_i = 1'b1;
        tick(3);
        check("fault_sticky", 32'(fault_o), 1);
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        check("restart_fault_clr", 32'(fault_o), 0);
        check("restart_retry_clr", 32'(retry_cnt_o), 0);
        check("restart_pll_reset", 32'(pll_reset_o), 1);
        wait_sig("restart_ready", SIG_RDY, 1'b1, 100, n);
        check("restart_ready_cycles", n, RESEQ_CYC);

        // restart on the same edge as a timeout
        pll_lock_i = 1'b0;
        do_reset();
        tick(PLL_RST_CYC + LOCK_TIMEOUT_CYC - 1);
        check("pre_timeout_retry", 32'(retry_cnt_o), 0);
        check("pre_timeout_pll", 32'(pll_reset_o), 0);
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        check("restart_vs_timeout_retry", 32'(retry_cnt_o), 0);
        check("restart_vs_timeout_pll", 32'(pll_reset_o), 1);
        check("restart_vs_timeout_fault", 32'(fault_o), 0);
        wait_sig("restart_vs_timeout_pulse", SIG_PLL, 1'b0, 20, n);
        check("restart_vs_timeout_pulse_cycles", n, PLL_RST_CYC);

        // ---------------- 6. Loss counter saturation ----------------
        pll_lock_i = 1'b1;
        wait_sig("sat_first_ready", SIG_RDY, 1'b1, 100, n);
        check("sat_start_loss", 32'(loss_cnt_o), 0);
        for (int i = 1; i <= 300; i++) begin
            pll_lock_i = 1'b0;
            wait_sig("sat_drop", SIG_RDY, 1'b0, 20, n);
            pll_lock_i = 1'b1;
            wait_sig("sat_back", SIG_RDY, 1'b1, 60, n);
            if (i == 100) check("sat_loss_100", 32'(loss_cnt_o), 100);
        end
        check("sat_loss_255", 32'(loss_cnt_o), 255);
        check("sat_ready", 32'(ready_o), 1);

        // reset while in REL_SER
        pll_lock_i = 1'b0;
        wait_sig("relser_drop", SIG_RDY, 1'b0, 20, n);
        pll_lock_i = 1'b1;
        wait_sig("relser_enter", SIG_SER, 1'b0, 60, n);
        check("relser_pix_high", 32'(pix_rst_o), 1);
        check("relser_ready_low", 32'(ready_o), 0);
        reset = 1'b1;
        tick(1);
        check_reset_vals("mid_relser_rst");
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
